// File: rtl/st_channel_mapper_pkg.sv
// Shared types and helpers for the Avalon-ST channel mapper.
package st_channel_mapper_pkg;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_PASS = 2'd1;
  localparam logic [STATE_W-1:0] ST_DROP = 2'd2;

  // Working width of the helper arithmetic; channel and counter widths must stay below it.
  localparam int unsigned MAP_W = 32;

  // Returns {legal, mapped}: mapped = ch + offset wrapped to out_w+1 bits, legal = mapped <= max_ch.
  function automatic logic [MAP_W:0] map_channel(input logic [MAP_W-1:0] ch,
                                                 input logic [MAP_W-1:0] offset,
                                                 input logic [MAP_W-1:0] max_ch,
                                                 input int unsigned out_w);
    logic [MAP_W:0] sum;
    logic [MAP_W:0] mask;
    sum  = {1'b0, ch} + {1'b0, offset};
    mask = ((MAP_W+1)'(1) << (out_w + 1)) - (MAP_W+1)'(1);
    sum  = sum & mask;
    return {(sum <= {1'b0, max_ch}), sum[MAP_W-1:0]};
  endfunction

  // Increment that sticks at 2^w-1.
  function automatic logic [MAP_W-1:0] sat_inc(input logic [MAP_W-1:0] v, input int unsigned w);
    logic [MAP_W-1:0] max_v;
    max_v = (MAP_W'(1) << w) - MAP_W'(1);
    return (v >= max_v) ? v : v + MAP_W'(1);
  endfunction

endpackage

// File: rtl/st_skid_buffer.sv
// Generic 2-entry registered valid/ready buffer: output register plus one skid slot.
module st_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push_c;
  logic         out_free_c;
  logic         skid_next_c;

  assign push_c     = in_valid & in_ready;
  assign out_free_c = ~out_valid | out_ready;

  // Occupancy of the skid slot after this edge; drives the registered ready.
  always_comb begin
    skid_next_c = skid_valid;
    if (out_free_c) begin
      skid_next_c = 1'b0;
    end else if (push_c) begin
      skid_next_c = 1'b1;
    end
  end

  // Output register refills from the skid slot first so ordering is preserved.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (out_free_c) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= push_c;
          if (push_c) begin
            out_data <= in_data;
          end
        end
      end else if (push_c) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
      in_ready <= ~skid_next_c;
    end
  end

endmodule

// File: rtl/st_channel_mapper.sv
// Avalon-ST channel adapter: offset + range-check at SOP, drop/orphan filtering, skid-buffered output.
module st_channel_mapper
  import st_channel_mapper_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned IN_CHANNEL_W   = 1,
  parameter int unsigned OUT_CHANNEL_W  = 8,
  parameter int unsigned CHANNEL_OFFSET = 0,
  parameter int unsigned MAX_CHANNEL    = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [IN_CHANNEL_W-1:0]  in_channel,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [OUT_CHANNEL_W-1:0] out_channel,
  input  logic                     cnt_clear,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         orphan_count
);

  localparam int unsigned PAY_W = DATA_W + 2 + OUT_CHANNEL_W;

  logic [STATE_W-1:0]       state;
  logic [STATE_W-1:0]       state_next;
  logic [OUT_CHANNEL_W-1:0] chan_q;
  logic [OUT_CHANNEL_W-1:0] chan_next;
  logic [OUT_CHANNEL_W-1:0] pay_chan_c;
  logic                     accept_c;
  logic                     fwd_c;
  logic                     drop_inc_c;
  logic                     orphan_inc_c;
  logic [MAP_W:0]           map_c;
  logic                     legal_c;
  logic [OUT_CHANNEL_W-1:0] mapped_c;
  logic                     map_unused;
  logic [PAY_W-1:0]         buf_in;
  logic [PAY_W-1:0]         buf_out;

  assign map_c      = map_channel(MAP_W'(in_channel), MAP_W'(CHANNEL_OFFSET),
                                  MAP_W'(MAX_CHANNEL), OUT_CHANNEL_W);
  assign legal_c    = map_c[MAP_W];
  assign mapped_c   = map_c[OUT_CHANNEL_W-1:0];
  assign map_unused = ^map_c[MAP_W-1:OUT_CHANNEL_W];

  // Dropped beats are still accepted, so only the buffer ever stalls the sink.
  assign accept_c = in_valid & in_ready;

  // Packet filter: decides forward/discard and counter events for each accepted beat.
  always_comb begin
    state_next   = state;
    chan_next    = chan_q;
    pay_chan_c   = chan_q;
    fwd_c        = 1'b0;
    drop_inc_c   = 1'b0;
    orphan_inc_c = 1'b0;
    if (accept_c) begin
      if (in_startofpacket) begin
        // A SOP while passing means the previous packet lost its EOP.
        if (state == ST_PASS) begin
          orphan_inc_c = 1'b1;
        end
        if (legal_c) begin
          fwd_c      = 1'b1;
          chan_next  = mapped_c;
          pay_chan_c = mapped_c;
          state_next = in_endofpacket ? ST_IDLE : ST_PASS;
        end else begin
          drop_inc_c = 1'b1;
          state_next = in_endofpacket ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state)
          ST_PASS: begin
            fwd_c = 1'b1;
            if (in_endofpacket) state_next = ST_IDLE;
          end
          ST_DROP: begin
            if (in_endofpacket) state_next = ST_IDLE;
          end
          default: begin
            orphan_inc_c = 1'b1;
          end
        endcase
      end
    end
  end

  // Filter state and the channel latched at SOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      chan_q <= '0;
    end else begin
      state  <= state_next;
      chan_q <= chan_next;
    end
  end

  // Saturating status counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count   <= '0;
      orphan_count <= '0;
    end else if (cnt_clear) begin
      drop_count   <= '0;
      orphan_count <= '0;
    end else begin
      if (drop_inc_c)   drop_count   <= CNT_W'(sat_inc(MAP_W'(drop_count), CNT_W));
      if (orphan_inc_c) orphan_count <= CNT_W'(sat_inc(MAP_W'(orphan_count), CNT_W));
    end
  end

  assign buf_in = {in_data, in_startofpacket, in_endofpacket, pay_chan_c};

  st_skid_buffer #(
    .W(PAY_W)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (fwd_c),
    .in_ready (in_ready),
    .in_data  (buf_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign out_data          = buf_out[PAY_W-1 -: DATA_W];
  assign out_startofpacket = buf_out[OUT_CHANNEL_W+1];
  assign out_endofpacket   = buf_out[OUT_CHANNEL_W];
  assign out_channel       = buf_out[OUT_CHANNEL_W-1:0];

endmodule

// File: tb/tb_st_channel_mapper.sv
// Scoreboard bench for st_channel_mapper with a packet-level reference model.
module tb_st_channel_mapper;

  localparam int unsigned DW   = 8;
  localparam int unsigned ICW  = 3;
  localparam int unsigned OCW  = 8;
  localparam int unsigned OFF  = 250;
  localparam int unsigned MAXC = 253;
  localparam int unsigned CW   = 4;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic           sop;
    logic           eop;
    logic [OCW-1:0] ch;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_ready;
  logic           in_valid = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic           in_startofpacket = 1'b0;
  logic           in_endofpacket = 1'b0;
  logic [ICW-1:0] in_channel = '0;
  logic           out_ready = 1'b1;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic           out_startofpacket;
  logic           out_endofpacket;
  logic [OCW-1:0] out_channel;
  logic           cnt_clear = 1'b0;
  logic [CW-1:0]  drop_count;
  logic [CW-1:0]  orphan_count;

  always #5 clk = ~clk;

  st_channel_mapper #(
    .DATA_W(DW), .IN_CHANNEL_W(ICW), .OUT_CHANNEL_W(OCW),
    .CHANNEL_OFFSET(OFF), .MAX_CHANNEL(MAXC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_channel(in_channel),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_channel(out_channel),
    .cnt_clear(cnt_clear), .drop_count(drop_count), .orphan_count(orphan_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int stall_cycles = 0;
  int last_acc_cyc = 0;
  int pop_cycles[$];
  beat_t sb[$];
  bit rnd_ready = 1'b0;

  // Reference model: packet context and expected counters.
  int m_ctx = 0;            // 0 = between packets, 1 = forwarding, 2 = discarding
  logic [OCW-1:0] m_ch = '0;
  int exp_drop = 0;
  int exp_orphan = 0;
  int cmax = (1 << CW) - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v < cmax) ? v + 1 : cmax;
  endfunction

  task automatic model_accept(input bit sop, input bit eop, input int ch, input int data, input bit clr);
    int  m;
    bit  legal;
    m     = (ch + int'(OFF)) % (1 << (OCW + 1));
    legal = (m <= int'(MAXC));
    if (sop) begin
      if (m_ctx == 1) exp_orphan = sat(exp_orphan);
      if (legal) begin
        m_ch = OCW'(m);
        sb.push_back({DW'(data), 1'b1, eop, OCW'(m)});
        m_ctx = eop ? 0 : 1;
      end else begin
        exp_drop = sat(exp_drop);
        m_ctx = eop ? 0 : 2;
      end
    end else if (m_ctx == 1) begin
      sb.push_back({DW'(data), 1'b0, eop, m_ch});
      if (eop) m_ctx = 0;
    end else if (m_ctx == 2) begin
      if (eop) m_ctx = 0;
    end else begin
      exp_orphan = sat(exp_orphan);
    end
    if (clr) begin
      exp_drop = 0;
      exp_orphan = 0;
    end
  endtask

  // Monitor: pops expected beats on every handshake and checks the hold rule under backpressure.
  beat_t held;
  bit held_v = 1'b0;
  always @(negedge clk) begin
    beat_t got;
    beat_t exp;
    got = {out_data, out_startofpacket, out_endofpacket, out_channel};
    if (!reset_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_payload", got, held);
      end
      if (out_valid && out_ready) begin
        pop_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %h with empty scoreboard (t=%0t)", got, $time);
        end else begin
          exp = sb.pop_front();
          check("out_beat", got, exp);
        end
      end
      held_v = out_valid && !out_ready;
      held   = got;
    end
  end

  // Random sink backpressure for the soak phase.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_beat(input bit sop, input bit eop, input int ch, input int data, input bit clr);
    int t;
    in_valid = 1'b1;
    in_startofpacket = sop;
    in_endofpacket = eop;
    in_channel = ICW'(ch);
    in_data = DW'(data);
    cnt_clear = clr;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      stall_cycles++;
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
    end else begin
      last_acc_cyc = cyc;
      n_acc++;
      model_accept(sop, eop, ch, data, clr);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt_clear = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, sb.size(), 0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_drop"}, drop_count, exp_drop);
    check({name, "_orphan"}, orphan_count, exp_orphan);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc;
    int acc0;
    int stall0;
    int orph0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_sop_eop", {out_startofpacket, out_endofpacket}, 0);
    check("rst_counts", {drop_count, orphan_count}, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Legal 4-beat packet: latency and back-to-back output.
    pop_cycles.delete();
    first_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(i == 0, i == 3, 1, 8'h10 + i, 1'b0);
      if (i == 0) first_acc = last_acc_cyc;
    end
    drain("t1_drain");
    check("t1_beats", pop_cycles.size(), 4);
    if (pop_cycles.size() == 4) begin
      check("t1_latency", pop_cycles[0] - first_acc, 1);
      check("t1_consecutive", pop_cycles[3] - pop_cycles[0], 3);
    end

    // Illegal channels (above max and overflow) are dropped without stalling.
    stall0 = stall_cycles;
    for (int i = 0; i < 3; i++) send_beat(i == 0, i == 2, 4, 8'h20 + i, 1'b0);
    for (int i = 0; i < 2; i++) send_beat(i == 0, i == 1, 7, 8'h30 + i, 1'b0);
    check("t2_no_stall", stall_cycles - stall0, 0);
    drain("t2_drain");
    check_counts("t2");
    for (int i = 0; i < 2; i++) send_beat(i == 0, i == 1, 0, 8'h40 + i, 1'b0);
    drain("t2b_drain");

    // in_channel wiggling mid-packet must not change out_channel.
    send_beat(1, 0, 2, 8'h50, 1'b0);
    send_beat(0, 0, 5, 8'h51, 1'b0);
    send_beat(0, 0, 7, 8'h52, 1'b0);
    send_beat(0, 1, 0, 8'h53, 1'b0);
    drain("t3_drain");

    // Orphan beat in idle, then a truncated packet.
    orph0 = orphan_count;
    send_beat(0, 0, 1, 8'h60, 1'b0);
    send_beat(1, 0, 3, 8'h61, 1'b0);
    send_beat(0, 0, 3, 8'h62, 1'b0);
    send_beat(1, 0, 1, 8'h63, 1'b0);
    send_beat(0, 1, 2, 8'h64, 1'b0);
    drain("t4_drain");
    check("t4_orphan_delta", orphan_count - orph0, 2);
    check_counts("t4");

    // Backpressure: two beats absorbed, then the sink stalls.
    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(i == 0, i == 5, 2, 8'h70 + i, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        check("t5_absorbed", n_acc - acc0, 2);
        check("t5_in_ready_low", in_ready, 0);
        check("t5_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    drain("t5_drain");

    // Randomized soak with random backpressure and occasional clears.
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_beat($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                $urandom_range(0, 49) == 0);
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain("t6_drain");
    check_counts("t6");

    // Saturation and clear priority.
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    exp_drop = 0;
    exp_orphan = 0;
    check_counts("t7_clear");
    for (int i = 0; i < (1 << CW) + 3; i++) send_beat(0, 0, 0, i, 1'b0);
    check_counts("t7_sat");
    send_beat(0, 0, 0, 8'h99, 1'b1);
    check_counts("t7_clr_inc");

    // Mid-packet asynchronous reset.
    send_beat(1, 1, 5, 8'hA0, 1'b0);
    send_beat(0, 1, 0, 8'hA1, 1'b0);
    check_counts("t8_pre");
    out_ready = 1'b0;
    send_beat(1, 0, 0, 8'hAB, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    m_ctx = 0;
    exp_drop = 0;
    exp_orphan = 0;
    check("t8_out_valid", out_valid, 0);
    check("t8_out_data", out_data, 0);
    check("t8_out_channel", out_channel, 0);
    check("t8_sop_eop", {out_startofpacket, out_endofpacket}, 0);
    check("t8_in_ready", in_ready, 0);
    check_counts("t8_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    send_beat(0, 1, 0, 8'h55, 1'b0);
    drain("t8_drain");
    check_counts("t8_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
